// File: rtl/rename_freelist_ctrl_pkg.sv
// rtl/rename_freelist_ctrl_pkg.sv - shared sizes, types and pointer helper for the rename free list
package rename_freelist_ctrl_pkg;

   localparam int DP_NUM        = 2;
   localparam int RT_NUM        = 2;
   localparam int ARCH_NUM      = 32;
   localparam int PRF_NUM       = 64;
   localparam int TAG_IDX_WIDTH = 6;

   localparam int FL_ENTRY = PRF_NUM - ARCH_NUM;
   localparam int PTR_W    = $clog2(FL_ENTRY);
   localparam int CNT_W    = PTR_W + 1;

   typedef enum logic {FL_NORMAL, FL_RECOVER} FL_STATE;

   typedef struct packed {
      logic req;
      logic wr_en;
   } DP_FL;

   typedef struct packed {
      logic                     gnt;
      logic [TAG_IDX_WIDTH-1:0] tag;
   } FL_DP;

   typedef struct packed {
      logic                     valid;
      logic                     wr_en;
      logic [TAG_IDX_WIDTH-1:0] tag_old;
   } RT_FL;

   // Circular pointer advance; FL_ENTRY need not be a power of two, so the wrap
   // is an explicit compare-and-subtract. inc never exceeds FL_ENTRY.
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                input logic [CNT_W-1:0] inc);
      logic [CNT_W:0] sum;
      sum = {2'b00, ptr} + {1'b0, inc};
      if (sum >= (CNT_W+1)'(FL_ENTRY))
         sum = sum - (CNT_W+1)'(FL_ENTRY);
      return sum[PTR_W-1:0];
   endfunction

endpackage

// File: rtl/rename_freelist_ctrl_if.sv
// rtl/rename_freelist_ctrl_if.sv - dispatch, retire and status signals of the free list
interface rename_freelist_ctrl_if;
   import rename_freelist_ctrl_pkg::*;

   logic                              rollback_i;
   logic [DP_NUM-1:0]                 dp_req_i;
   logic [DP_NUM-1:0]                 dp_wr_en_i;
   logic [DP_NUM-1:0]                 dp_gnt_o;
   logic [DP_NUM*TAG_IDX_WIDTH-1:0]   dp_tag_o;
   logic [RT_NUM-1:0]                 rt_valid_i;
   logic [RT_NUM-1:0]                 rt_wr_en_i;
   logic [RT_NUM*TAG_IDX_WIDTH-1:0]   rt_tag_old_i;
   logic [CNT_W-1:0]                  avail_cnt_o;
   logic                              recover_o;
   logic                              ovf_o;

   modport slave (
      input  rollback_i, dp_req_i, dp_wr_en_i, rt_valid_i, rt_wr_en_i, rt_tag_old_i,
      output dp_gnt_o, dp_tag_o, avail_cnt_o, recover_o, ovf_o
   );

   modport master (
      output rollback_i, dp_req_i, dp_wr_en_i, rt_valid_i, rt_wr_en_i, rt_tag_old_i,
      input  dp_gnt_o, dp_tag_o, avail_cnt_o, recover_o, ovf_o
   );

endinterface

// File: rtl/rename_freelist_ctrl_fl_grant_prefix.sv
// rtl/rename_freelist_ctrl_fl_grant_prefix.sv - in-order prefix count of tag demand and grant chain
module fl_grant_prefix
   import rename_freelist_ctrl_pkg::*;
(
   input  FL_STATE                        i_state,
   input  DP_FL    [DP_NUM-1:0]           i_dp,
   input  logic    [CNT_W-1:0]            i_count,
   output logic    [DP_NUM-1:0]           o_gnt,
   output logic    [DP_NUM-1:0][CNT_W-1:0] o_need,
   output logic    [CNT_W-1:0]            o_n_alloc
);

   // Walk lanes in program order; the first ungranted lane blocks all later lanes.
   always_comb begin
      logic             w_blocked;
      logic [CNT_W-1:0] w_need;
      logic [CNT_W-1:0] w_need_k;
      o_gnt     = '0;
      o_need    = '0;
      o_n_alloc = '0;
      w_blocked = (i_state != FL_NORMAL);
      w_need    = '0;
      w_need_k  = '0;
      for (int k = 0; k < DP_NUM; k++) begin
         w_need_k  = w_need + CNT_W'(i_dp[k].req & i_dp[k].wr_en);
         o_need[k] = w_need_k;
         if (!w_blocked && i_dp[k].req && (w_need_k <= i_count)) begin
            o_gnt[k] = 1'b1;
            w_need   = w_need_k;
         end else begin
            w_blocked = 1'b1;
         end
      end
      o_n_alloc = w_need;
   end

endmodule

// File: rtl/rename_freelist_ctrl.sv
// rtl/rename_freelist_ctrl.sv - physical tag free list with in-order grant, retire reclaim and rollback restore
module rename_freelist_ctrl
   import rename_freelist_ctrl_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   rename_freelist_ctrl_if.slave bus
);

   logic [TAG_IDX_WIDTH-1:0]        r_fl [FL_ENTRY];
   logic [PTR_W-1:0]                r_head;
   logic [PTR_W-1:0]                r_tail;
   logic [CNT_W-1:0]                r_count;
   logic                            r_ovf;
   FL_STATE                         r_state;
   FL_STATE                         w_state_nxt;

   DP_FL [DP_NUM-1:0]               w_dp;
   RT_FL [RT_NUM-1:0]               w_rt;
   FL_DP [DP_NUM-1:0]               w_fl_dp;
   logic [DP_NUM-1:0]               w_gnt;
   logic [DP_NUM-1:0][CNT_W-1:0]    w_need;
   logic [CNT_W-1:0]                w_n_alloc;
   logic [CNT_W-1:0]                w_n_alloc_eff;
   logic [CNT_W-1:0]                w_n_free;
   logic [RT_NUM-1:0]               w_fr_en;
   logic [RT_NUM-1:0][PTR_W-1:0]    w_fr_idx;
   logic [PTR_W-1:0]                w_tail_nxt;
   logic [CNT_W:0]                  w_cnt_sum;
   logic                            w_ovf_hit;

   // Unpack the flat lane vectors into per-lane records.
   always_comb begin
      w_dp = '0;
      w_rt = '0;
      for (int k = 0; k < DP_NUM; k++) begin
         w_dp[k].req   = bus.dp_req_i[k];
         w_dp[k].wr_en = bus.dp_wr_en_i[k];
      end
      for (int j = 0; j < RT_NUM; j++) begin
         w_rt[j].valid   = bus.rt_valid_i[j];
         w_rt[j].wr_en   = bus.rt_wr_en_i[j];
         w_rt[j].tag_old = bus.rt_tag_old_i[j*TAG_IDX_WIDTH +: TAG_IDX_WIDTH];
      end
   end

   fl_grant_prefix u_grant (
      .i_state   (r_state),
      .i_dp      (w_dp),
      .i_count   (r_count),
      .o_gnt     (w_gnt),
      .o_need    (w_need),
      .o_n_alloc (w_n_alloc)
   );

   // A granted writing lane takes the need_k-th tag counted from head.
   always_comb begin
      w_fl_dp = '0;
      for (int k = 0; k < DP_NUM; k++) begin
         w_fl_dp[k].gnt = w_gnt[k];
         if (w_gnt[k] && w_dp[k].wr_en)
            w_fl_dp[k].tag = r_fl[ptr_add(r_head, w_need[k] - CNT_W'(1))];
      end
   end

   // Drive the packed grant/tag outputs.
   always_comb begin
      bus.dp_gnt_o = '0;
      bus.dp_tag_o = '0;
      for (int k = 0; k < DP_NUM; k++) begin
         bus.dp_gnt_o[k]                                  = w_fl_dp[k].gnt;
         bus.dp_tag_o[k*TAG_IDX_WIDTH +: TAG_IDX_WIDTH]   = w_fl_dp[k].tag;
      end
   end

   // Freed tags land at consecutive slots from tail, in retire-lane order.
   always_comb begin
      w_n_free = '0;
      w_fr_en  = '0;
      w_fr_idx = '0;
      for (int j = 0; j < RT_NUM; j++) begin
         w_fr_en[j]  = w_rt[j].valid & w_rt[j].wr_en;
         w_fr_idx[j] = ptr_add(r_tail, w_n_free);
         if (w_fr_en[j])
            w_n_free = w_n_free + CNT_W'(1);
      end
      w_tail_nxt = ptr_add(r_tail, w_n_free);
   end

   // Allocation in a rollback cycle is thrown away, so it does not count.
   always_comb begin
      w_n_alloc_eff = bus.rollback_i ? '0 : w_n_alloc;
      w_cnt_sum     = {1'b0, r_count} - {1'b0, w_n_alloc_eff} + {1'b0, w_n_free};
      w_ovf_hit     = (w_cnt_sum > (CNT_W+1)'(FL_ENTRY));
   end

   // Next state: any rollback enters (or re-enters) RECOVER; a quiet cycle returns to NORMAL.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FL_NORMAL:  if (bus.rollback_i)  w_state_nxt = FL_RECOVER;
         FL_RECOVER: if (!bus.rollback_i) w_state_nxt = FL_NORMAL;
         default:    w_state_nxt = FL_NORMAL;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_state <= FL_NORMAL;
      else
         r_state <= w_state_nxt;
   end

   // Buffer, pointers, count and sticky overflow; retire writes always land before a rollback restore.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FL_ENTRY; i++)
            r_fl[i] <= TAG_IDX_WIDTH'(ARCH_NUM + i);
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= CNT_W'(FL_ENTRY);
         r_ovf   <= 1'b0;
      end else begin
         for (int j = 0; j < RT_NUM; j++)
            if (w_fr_en[j])
               r_fl[w_fr_idx[j]] <= w_rt[j].tag_old;
         r_tail <= w_tail_nxt;
         if (w_ovf_hit)
            r_ovf <= 1'b1;
         if (bus.rollback_i) begin
            r_head  <= w_tail_nxt;
            r_count <= CNT_W'(FL_ENTRY);
         end else begin
            r_head  <= ptr_add(r_head, w_n_alloc);
            r_count <= w_ovf_hit ? CNT_W'(FL_ENTRY) : w_cnt_sum[CNT_W-1:0];
         end
      end
   end

   assign bus.avail_cnt_o = r_count;
   assign bus.recover_o   = (r_state == FL_RECOVER);
   assign bus.ovf_o       = r_ovf;

endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// tb/tb_rename_freelist_ctrl.sv - scoreboard bench for the rename free list against a queue model
module tb_rename_freelist_ctrl;

   typedef struct packed {
      logic [1:0] gnt;
      logic [5:0] tag1;
      logic [5:0] tag0;
      logic [5:0] avail;
      logic       rec;
      logic       ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rename_freelist_ctrl_if bus ();

   rename_freelist_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Model: free_q is the free list in allocation order; alloc_q holds allocated
   // tags (oldest first) whose slots have not yet been overwritten by a free.
   int   free_q[$];
   int   alloc_q[$];
   bit   m_rec;
   bit   m_ovf;
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic model_reset();
      free_q.delete();
      alloc_q.delete();
      for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
      m_rec = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic drive_idle();
      bus.rollback_i   = 1'b0;
      bus.dp_req_i     = 2'b00;
      bus.dp_wr_en_i   = 2'b00;
      bus.rt_valid_i   = 2'b00;
      bus.rt_wr_en_i   = 2'b00;
      bus.rt_tag_old_i = '0;
   endtask

   // Entered just after a rising edge; checks happen while reset is held, before any edge.
   task automatic do_reset();
      vec_t e;
      rst = 1'b1;
      drive_idle();
      model_reset();
      e = '{gnt: 2'b00, tag1: 6'd0, tag0: 6'd0, avail: 6'd32, rec: 1'b0, ovf: 1'b0};
      exp_q.push_back(e);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One cycle: predict outputs from the model, drive, queue the prediction, advance the model.
   task automatic step(input logic [1:0] req, input logic [1:0] we,
                       input logic [1:0] rtv, input logic [1:0] rtwe_in,
                       input logic [5:0] rtag0, input logic [5:0] rtag1,
                       input logic rb, input bit clamp);
      vec_t       e;
      logic [1:0] rtwe;
      logic [5:0] tg [2];
      logic [5:0] rt [2];
      int         need, nk, nf, eff, cap, t;
      bit         blocked;
      rtwe  = rtwe_in;
      rt[0] = rtag0;
      rt[1] = rtag1;
      tg[0] = '0;
      tg[1] = '0;
      e     = '0;
      need  = 0;
      blocked = m_rec;
      for (int k = 0; k < 2; k++) begin
         nk = need + ((req[k] && we[k]) ? 1 : 0);
         if (!blocked && req[k] && nk <= free_q.size()) begin
            e.gnt[k] = 1'b1;
            if (we[k]) tg[k] = 6'(free_q[nk-1]);
            need = nk;
         end else begin
            blocked = 1'b1;
         end
      end
      eff = rb ? 0 : need;
      if (clamp) begin
         cap = 32 - (free_q.size() - eff);
         nf  = 0;
         for (int j = 0; j < 2; j++)
            if (rtv[j] && rtwe[j]) begin
               if (nf >= cap) rtwe[j] = 1'b0;
               else nf++;
            end
      end
      e.tag0  = tg[0];
      e.tag1  = tg[1];
      e.avail = 6'(free_q.size());
      e.rec   = m_rec;
      e.ovf   = m_ovf;

      bus.dp_req_i     = req;
      bus.dp_wr_en_i   = we;
      bus.rt_valid_i   = rtv;
      bus.rt_wr_en_i   = rtwe;
      bus.rt_tag_old_i = {rt[1], rt[0]};
      bus.rollback_i   = rb;
      exp_q.push_back(e);

      nf = 0;
      for (int j = 0; j < 2; j++) if (rtv[j] && rtwe[j]) nf++;
      if (free_q.size() - eff + nf > 32) begin
         m_ovf = 1'b1;
      end else begin
         for (int i = 0; i < eff; i++) begin
            t = free_q.pop_front();
            alloc_q.push_back(t);
         end
         for (int j = 0; j < 2; j++)
            if (rtv[j] && rtwe[j]) begin
               void'(alloc_q.pop_front());
               free_q.push_back(int'(rt[j]));
            end
         if (rb) begin
            free_q = {alloc_q, free_q};
            alloc_q.delete();
         end
      end
      m_rec = rb;
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the DUT against the oldest queued prediction, mid-cycle.
   always @(negedge clk) begin
      vec_t e, a;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a.gnt   = bus.dp_gnt_o;
         a.tag1  = bus.dp_tag_o[11:6];
         a.tag0  = bus.dp_tag_o[5:0];
         a.avail = bus.avail_cnt_o;
         a.rec   = bus.recover_o;
         a.ovf   = bus.ovf_o;
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL vec%0d @%0t: got gnt=%b tag0=%0d tag1=%0d avail=%0d rec=%b ovf=%b, required gnt=%b tag0=%0d tag1=%0d avail=%0d rec=%b ovf=%b",
                     n_vec, $time, a.gnt, a.tag0, a.tag1, a.avail, a.rec, a.ovf,
                     e.gnt, e.tag0, e.tag1, e.avail, e.rec, e.ovf);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete within time limit");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] req, rtv;
      drive_idle();
      do_reset();

      // Dual allocate after reset, then mixed wr_en.
      step(2'b11, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      step(2'b11, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      step(2'b11, 2'b10, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      step(2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);

      // Drain to empty.
      while (free_q.size() >= 2) step(2'b11, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      if (free_q.size() == 1) step(2'b01, 2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      // Empty: writer denied while tag 5 is retired; tag 5 is allocatable next cycle.
      step(2'b11, 2'b01, 2'b01, 2'b01, 6'd5, 6'd0, 1'b0, 1'b1);
      step(2'b01, 2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      // Empty: non-writing lane 0 still granted, writing lane 1 denied.
      step(2'b11, 2'b10, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      // One tag left: only lane 0 granted.
      step(2'b00, 2'b00, 2'b01, 2'b01, 6'd7, 6'd0, 1'b0, 1'b1);
      step(2'b11, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      step(2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);

      // Rollback with a simultaneous retire.
      do_reset();
      for (int i = 0; i < 5; i++) step(2'b11, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      step(2'b00, 2'b00, 2'b11, 2'b11, 6'd1, 6'd2, 1'b0, 1'b1);
      step(2'b00, 2'b00, 2'b01, 2'b01, 6'd3, 6'd0, 1'b0, 1'b1);
      step(2'b11, 2'b11, 2'b11, 2'b11, 6'd4, 6'd6, 1'b1, 1'b1);
      step(2'b11, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      step(2'b11, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);
      step(2'b11, 2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b1);

      // Overflow is sticky; async reset clears it between edges.
      do_reset();
      step(2'b00, 2'b00, 2'b01, 2'b01, 6'd9, 6'd0, 1'b0, 1'b0);
      step(2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      step(2'b00, 2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0, 1'b0);
      do_reset();

      // Randomized traffic with occasional rollbacks.
      for (int c = 0; c < 1500; c++) begin
         case ($urandom_range(0, 2))
            0:       req = 2'b00;
            1:       req = 2'b01;
            default: req = 2'b11;
         endcase
         case ($urandom_range(0, 2))
            0:       rtv = 2'b00;
            1:       rtv = 2'b01;
            default: rtv = 2'b11;
         endcase
         step(req, 2'($urandom_range(0, 3)), rtv, 2'($urandom_range(0, 3)),
              6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              ($urandom_range(0, 15) == 0), 1'b1);
      end

      drive_idle();
      @(negedge clk);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
